// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked registered ALU with iterative MUL/DIVU
// Optional status flags are built only when ALU_PIPE_FLAGS_EN is defined.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic [2:0]       flags
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
    localparam logic [SHW-1:0]   CNT_INIT = SHW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic                 fin_q, fin_d;
    logic                 div_q, div_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 c_out_q, c_out_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept, multi_op, load_res;
    logic [WIDTH:0]       a_x, b_x, cin_x;
    logic [WIDTH-1:0]     sc_out, mc_out, res_out;
    logic                 sc_c, mc_c, res_c;
    logic                 big_shift;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     hi, lo, diff;
    logic [WIDTH:0]       mul_sum, shifted;
    logic                 ge;
    logic [2*WIDTH-1:0]   mul_next, div_next;

    assign in_ready  = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign multi_op  = (alu_sel[3:1] == 3'b111);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign c_out     = c_out_q;

    assign a_x       = {1'b0, a_in};
    assign b_x       = {1'b0, b_in};
    assign cin_x     = {{WIDTH{1'b0}}, c_in};
    assign big_shift = (b_in >= W_VAL);
    assign shamt     = b_in[SHW-1:0];

    always_comb begin
        sc_out = '0;
        sc_c   = 1'b0;
        case (alu_sel)
            4'd0:         {sc_c, sc_out} = a_x + b_x + cin_x;
            4'd1:         {sc_c, sc_out} = a_x - b_x + cin_x;
            4'd13:        {sc_c, sc_out} = b_x - a_x + cin_x;
            4'd2:         sc_out = a_in | b_in;
            4'd3:         sc_out = a_in & b_in;
            4'd4:         sc_out = a_in ^ b_in;
            4'd5:         sc_out = ~(a_in | b_in);
            4'd6:         sc_out = ~(a_in & b_in);
            4'd7:         sc_out = ~(a_in ^ b_in);
            4'd8, 4'd10:  sc_out = big_shift ? '0 : (a_in << shamt);
            4'd9:         sc_out = big_shift ? '0 : (a_in >> shamt);
            4'd11:        sc_out = big_shift ? {WIDTH{a_in[WIDTH-1]}}
                                             : $unsigned($signed(a_in) >>> shamt);
            4'd12:        sc_out = ~b_in;
            default:      sc_out = '0;
        endcase
    end

    // acc holds {product high, multiplier} for MUL and {remainder, dividend/quotient} for DIVU
    always_comb begin
        hi       = acc_q[2*WIDTH-1:WIDTH];
        lo       = acc_q[WIDTH-1:0];
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, lo[WIDTH-1:1]};
        shifted  = {hi, lo[WIDTH-1]};
        ge       = (shifted >= {1'b0, opb_q});
        diff     = shifted[WIDTH-1:0] - opb_q;
        div_next = ge ? {diff, lo[WIDTH-2:0], 1'b1}
                      : {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
        if (div_q) begin
            mc_out = (opb_q == '0) ? '1 : lo;
            mc_c   = (opb_q == '0);
        end else begin
            mc_out = lo;
            mc_c   = |hi;
        end
    end

    assign load_res = (state_q == IDLE) ? (accept && !multi_op) : fin_q;
    assign res_out  = (state_q == BUSY) ? mc_out : sc_out;
    assign res_c    = (state_q == BUSY) ? mc_c : sc_c;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fin_d       = fin_q;
        div_d       = div_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        out_d       = out_q;
        c_out_d     = c_out_q;
        out_valid_d = out_valid_q && !out_ready;
        if (state_q == IDLE) begin
            if (accept && multi_op) begin
                state_d = BUSY;
                cnt_d   = CNT_INIT;
                fin_d   = 1'b0;
                div_d   = alu_sel[0];
                opb_d   = alu_sel[0] ? b_in : a_in;
                acc_d   = {{WIDTH{1'b0}}, alu_sel[0] ? a_in : b_in};
            end
        end else if (fin_q) begin
            state_d = IDLE;
            fin_d   = 1'b0;
        end else begin
            acc_d = div_q ? div_next : mul_next;
            if (cnt_q == '0) fin_d = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
        if (load_res) begin
            out_d       = res_out;
            c_out_d     = res_c;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fin_q       <= 1'b0;
            div_q       <= 1'b0;
            opb_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fin_q       <= fin_d;
            div_q       <= div_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic [2:0] flags_q, flags_d;
    logic       sc_ovf;
    logic       sa, sb, sr;

    // Signed overflow only exists for the add/subtract family; result sign includes c_in
    always_comb begin
        sa = a_in[WIDTH-1];
        sb = b_in[WIDTH-1];
        sr = sc_out[WIDTH-1];
        case (alu_sel)
            4'd0:    sc_ovf = (sa == sb) && (sr != sa);
            4'd1:    sc_ovf = (sa != sb) && (sr != sa);
            4'd13:   sc_ovf = (sa != sb) && (sr != sb);
            default: sc_ovf = 1'b0;
        endcase
        flags_d = flags_q;
        if (load_res)
            flags_d = {(state_q == IDLE) && sc_ovf, res_out[WIDTH-1], res_out == '0};
    end

    always_ff @(posedge clk) begin
        if (rst) flags_q <= 3'b000;
        else     flags_q <= flags_d;
    end

    assign flags = flags_q;
`else
    assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed vector bench for alu_pipe
module tb_alu_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out;
    logic [3:0]   alu_sel;
    logic [W-1:0] a_in, b_in, out;
    logic [2:0]   flags;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .c_out(c_out), .flags(flags)
    );

    typedef struct {
        logic [3:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] eo;
        logic         ec;
        logic [2:0]   ef;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] fx(input logic [2:0] f);
`ifdef ALU_PIPE_FLAGS_EN
        return f;
`else
        return 3'b000 & f;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_multi(input string name, input logic [3:0] sel, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] eo, input logic ec,
                             input logic [2:0] ef);
        int bad;
        bad = 0;
        alu_sel = sel; a_in = a; b_in = b; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        chk({name, "_ready"}, in_ready, 1'b1);
        tick;
        alu_sel = 4'd0; a_in = 16'h1111; b_in = 16'h2222;
        for (int k = 0; k <= 16; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            if (k == 16) in_valid = 1'b0;
            tick;
        end
        chk({name, "_busy"}, bad, 0);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_out"}, out, eo);
        chk({name, "_cout"}, c_out, ec);
        chk({name, "_flags"}, flags, fx(ef));
        tick;
        chk({name, "_drain"}, out_valid, 1'b0);
    endtask

    initial begin
        int bad;
        vt[0]  = '{4'd0,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 3'b110};
        vt[1]  = '{4'd0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'b001};
        vt[2]  = '{4'd0,  16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 3'b000};
        vt[3]  = '{4'd1,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 3'b010};
        vt[4]  = '{4'd1,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 3'b100};
        vt[5]  = '{4'd13, 16'h0002, 16'h0005, 1'b0, 16'h0003, 1'b0, 3'b000};
        vt[6]  = '{4'd2,  16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0, 3'b000};
        vt[7]  = '{4'd3,  16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 3'b010};
        vt[8]  = '{4'd4,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 3'b001};
        vt[9]  = '{4'd5,  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 3'b010};
        vt[10] = '{4'd6,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 3'b001};
        vt[11] = '{4'd7,  16'h1234, 16'h1234, 1'b0, 16'hFFFF, 1'b0, 3'b010};
        vt[12] = '{4'd8,  16'h0001, 16'd16,   1'b0, 16'h0000, 1'b0, 3'b001};
        vt[13] = '{4'd8,  16'h0001, 16'd4,    1'b0, 16'h0010, 1'b0, 3'b000};
        vt[14] = '{4'd9,  16'h8000, 16'd15,   1'b0, 16'h0001, 1'b0, 3'b000};
        vt[15] = '{4'd10, 16'h0003, 16'd1,    1'b0, 16'h0006, 1'b0, 3'b000};
        vt[16] = '{4'd11, 16'h8000, 16'd20,   1'b0, 16'hFFFF, 1'b0, 3'b010};
        vt[17] = '{4'd11, 16'h8000, 16'd4,    1'b0, 16'hF800, 1'b0, 3'b010};
        vt[18] = '{4'd11, 16'h4000, 16'd20,   1'b0, 16'h0000, 1'b0, 3'b001};
        vt[19] = '{4'd12, 16'h1234, 16'h00FF, 1'b0, 16'hFF00, 1'b0, 3'b010};
        vt[20] = '{4'd2,  16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0, 3'b000};

        rst = 1'b1; in_valid = 1'b0; alu_sel = 4'd0; a_in = '0; b_in = '0;
        c_in = 1'b0; out_ready = 1'b1;
        repeat (2) tick;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_out", out, 16'h0000);
        chk("rst_cout", c_out, 1'b0);
        chk("rst_flags", flags, 3'b000);
        chk("rst_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1'b1);

        // back-to-back single-cycle ops, one result per edge
        for (int i = 0; i < 21; i++) begin
            alu_sel = vt[i].sel; a_in = vt[i].a; b_in = vt[i].b; c_in = vt[i].cin;
            in_valid = 1'b1;
            tick;
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_out", i), out, vt[i].eo);
            chk($sformatf("vec%0d_cout", i), c_out, vt[i].ec);
            chk($sformatf("vec%0d_flags", i), flags, fx(vt[i].ef));
        end
        in_valid = 1'b0;
        tick;
        chk("vec_drain", out_valid, 1'b0);

        // downstream stall: result holds, new op waits, then accepted on the consume edge
        out_ready = 1'b0;
        alu_sel = 4'd1; a_in = 16'd3; b_in = 16'd5; c_in = 1'b0; in_valid = 1'b1;
        tick;
        alu_sel = 4'd0; a_in = 16'd1; b_in = 16'd1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d_valid", k), out_valid, 1'b1);
            chk($sformatf("stall%0d_out", k), out, 16'hFFFE);
            chk($sformatf("stall%0d_cout", k), c_out, 1'b1);
            chk($sformatf("stall%0d_ready", k), in_ready, 1'b0);
            if (k < 3) tick;
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", in_ready, 1'b1);
        tick;
        chk("chain_valid", out_valid, 1'b1);
        chk("chain_out", out, 16'h0002);
        chk("chain_cout", c_out, 1'b0);
        in_valid = 1'b0;
        tick;
        chk("chain_drain", out_valid, 1'b0);

        run_multi("mul1", 4'd14, 16'h0100, 16'h0101, 16'h0100, 1'b1, 3'b000);
        run_multi("mul2", 4'd14, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 3'b000);
        run_multi("mul3", 4'd14, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 3'b000);
        run_multi("div1", 4'd15, 16'd100,  16'd7,    16'd14,   1'b0, 3'b000);
        run_multi("div0", 4'd15, 16'd5,    16'd0,    16'hFFFF, 1'b1, 3'b010);
        run_multi("div2", 4'd15, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 3'b010);
        run_multi("div3", 4'd15, 16'd3,    16'd9,    16'h0000, 1'b0, 3'b001);

        // reset in the middle of a multiply: no result may ever appear
        alu_sel = 4'd14; a_in = 16'h0100; b_in = 16'h0101; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        #1;
        chk("midrst_ready_now", in_ready, 1'b0);
        tick;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", in_ready, 1'b0);
        chk("midrst_out", out, 16'h0000);
        tick;
        chk("midrst_valid2", out_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", in_ready, 1'b1);
        bad = 0;
        repeat (25) begin
            tick;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        chk("midrst_no_stale", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
